// File: rtl/axis_join_pkg.sv
// Shared types for the first/end stream join path.
package axis_join_pkg;

  typedef enum logic {S_FIRST, S_END} join_state_e;

  localparam int unsigned SkidDepth = 2;

endpackage

// File: rtl/axis_skid_buf2.sv
// Two-entry output skid buffer; in_ready comes only from the registered fill level.
module axis_skid_buf2
  import axis_join_pkg::*;
#(
  parameter int unsigned W = 9
) (
  input  logic         clock,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] mem_q [SkidDepth];
  logic [W-1:0] mem_d [SkidDepth];
  logic         wr_q, wr_d, rd_q, rd_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         push, pop;

  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = mem_q[rd_q];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[wr_q] = in_data;
      wr_d        = ~wr_q;
    end
    if (pop) rd_d = ~rd_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/common_fifo.sv
// Synchronous FIFO, power-of-2 depth; a write into a full FIFO is accepted when a read happens too.
module common_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DSIZE = 8
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [DSIZE-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [DSIZE-1:0] rd_data,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DSIZE-1:0] mem_q [DEPTH];
  logic [DSIZE-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_wr, do_rd;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign rd_data = mem_q[rd_ptr_q];
  assign do_rd   = rd_en & ~empty;
  assign do_wr   = wr_en & (~full | do_rd);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_wr) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({do_wr, do_rd})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/axis_join_channel.sv
// Joins a first packet and its end packet into one stream packet and queues the first-part length.
module axis_join_channel
  import axis_join_pkg::*;
#(
  parameter int unsigned DSIZE     = 8,
  parameter int unsigned LSIZE     = 16,
  parameter int unsigned LEN_DEPTH = 4
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [DSIZE-1:0] first_tdata,
  input  logic             first_tvalid,
  output logic             first_tready,
  input  logic             first_tlast,
  input  logic [DSIZE-1:0] end_tdata,
  input  logic             end_tvalid,
  output logic             end_tready,
  input  logic             end_tlast,
  output logic [DSIZE-1:0] out_tdata,
  output logic             out_tvalid,
  input  logic             out_tready,
  output logic             out_tlast,
  output logic [LSIZE-1:0] len_tdata,
  output logic             len_tvalid,
  input  logic             len_tready,
  output logic             len_ovf
);

  join_state_e      state_q, state_d;
  logic [LSIZE-1:0] first_cnt_q, first_cnt_d, cnt_inc;
  logic             len_ovf_q, len_ovf_d;
  logic             skid_rdy, len_full, len_empty, len_pop, len_push;
  logic             first_hs, end_hs;
  logic [DSIZE:0]   skid_in;

  assign len_tvalid = ~len_empty;
  assign len_pop    = len_tvalid & len_tready;
  assign len_ovf    = len_ovf_q;

  // A last beat may only enter once its length has a FIFO slot (a same-cycle pop frees one).
  assign first_tready = ~rst & (state_q == S_FIRST) & skid_rdy
                      & ~(first_tlast & len_full & ~len_pop);
  assign end_tready   = ~rst & (state_q == S_END) & skid_rdy;
  assign first_hs     = first_tvalid & first_tready;
  assign end_hs       = end_tvalid & end_tready;

  assign cnt_inc  = (&first_cnt_q) ? first_cnt_q : first_cnt_q + LSIZE'(1);
  assign len_push = first_hs & first_tlast;
  assign skid_in  = (state_q == S_END) ? {end_tlast, end_tdata} : {1'b0, first_tdata};

  always_comb begin
    state_d     = state_q;
    first_cnt_d = first_cnt_q;
    len_ovf_d   = len_ovf_q;
    if (first_hs) begin
      if (&first_cnt_q) len_ovf_d = 1'b1;
      first_cnt_d = first_tlast ? '0 : cnt_inc;
      if (first_tlast) state_d = S_END;
    end
    if (end_hs && end_tlast) state_d = S_FIRST;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= S_FIRST;
      first_cnt_q <= '0;
      len_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      first_cnt_q <= first_cnt_d;
      len_ovf_q   <= len_ovf_d;
    end
  end

  axis_skid_buf2 #(
    .W (DSIZE + 1)
  ) u_skid (
    .clock     (clock),
    .rst       (rst),
    .in_data   (skid_in),
    .in_valid  (first_hs | end_hs),
    .in_ready  (skid_rdy),
    .out_data  ({out_tlast, out_tdata}),
    .out_valid (out_tvalid),
    .out_ready (out_tready)
  );

  common_fifo #(
    .DEPTH (LEN_DEPTH),
    .DSIZE (LSIZE)
  ) u_len_fifo (
    .clock   (clock),
    .rst     (rst),
    .wr_en   (len_push),
    .wr_data (cnt_inc),
    .full    (len_full),
    .rd_en   (len_pop),
    .rd_data (len_tdata),
    .empty   (len_empty)
  );

endmodule

// File: tb/tb_axis_join_channel.sv
// Self-checking bench for axis_join_channel: vector table, scoreboard queues and corner sequences.
module tb_axis_join_channel;

  localparam int DSIZE = 8;
  localparam int LSIZE = 16;
  localparam int LEN_DEPTH = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic             rst;
  logic [DSIZE-1:0] first_tdata, end_tdata, out_tdata, out4_tdata;
  logic             first_tvalid, first_tready, first_tlast;
  logic             end_tvalid, end_tready, end_tlast;
  logic             out_tvalid, out_tready, out_tlast, out4_tvalid, out4_tlast;
  logic [LSIZE-1:0] len_tdata;
  logic [3:0]       len4_tdata;
  logic             len_tvalid, len_tready, len_ovf, len4_tvalid, len4_ovf;
  logic             f4_tready, e4_tready;

  axis_join_channel #(.DSIZE(DSIZE), .LSIZE(LSIZE), .LEN_DEPTH(LEN_DEPTH)) u_dut (
    .clock(clock), .rst(rst),
    .first_tdata(first_tdata), .first_tvalid(first_tvalid), .first_tready(first_tready),
    .first_tlast(first_tlast),
    .end_tdata(end_tdata), .end_tvalid(end_tvalid), .end_tready(end_tready), .end_tlast(end_tlast),
    .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tlast(out_tlast),
    .len_tdata(len_tdata), .len_tvalid(len_tvalid), .len_tready(len_tready), .len_ovf(len_ovf)
  );

  // Narrow-counter instance fed the same stimulus, for the saturation case.
  axis_join_channel #(.DSIZE(DSIZE), .LSIZE(4), .LEN_DEPTH(LEN_DEPTH)) u_dut4 (
    .clock(clock), .rst(rst),
    .first_tdata(first_tdata), .first_tvalid(first_tvalid), .first_tready(f4_tready),
    .first_tlast(first_tlast),
    .end_tdata(end_tdata), .end_tvalid(end_tvalid), .end_tready(e4_tready), .end_tlast(end_tlast),
    .out_tdata(out4_tdata), .out_tvalid(out4_tvalid), .out_tready(out_tready),
    .out_tlast(out4_tlast),
    .len_tdata(len4_tdata), .len_tvalid(len4_tvalid), .len_tready(len_tready), .len_ovf(len4_ovf)
  );

  typedef struct {
    int flen;
    int elen;
    int lead;
    int exp_len;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp_q[$];
  int         len_q[$];
  int         len4_q[$];
  bit         mon_en = 1'b0;
  bit         tog_en = 1'b0;
  int         run = 0;
  int         max_run = 0;
  logic [8:0] exp_beat;
  int         exp_l;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (out_tvalid && out_tready) begin
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
    if (mon_en) begin
      if (out_tvalid && out_tready) begin
        if (exp_q.size() == 0) chk("out_unexpected", {out_tlast, out_tdata}, 32'hFFFF_FFFF);
        else begin
          exp_beat = exp_q.pop_front();
          chk("out_beat", {23'd0, out_tlast, out_tdata}, {23'd0, exp_beat});
        end
      end
      if (len_tvalid && len_tready) begin
        if (len_q.size() == 0) chk("len_unexpected", len_tdata, 32'hFFFF_FFFF);
        else begin
          exp_l = len_q.pop_front();
          chk("len", len_tdata, exp_l);
        end
      end
      if (len4_tvalid && len_tready) begin
        if (len4_q.size() == 0) chk("len4_unexpected", len4_tdata, 32'hFFFF_FFFF);
        else begin
          exp_l = len4_q.pop_front();
          chk("len4", len4_tdata, exp_l);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (tog_en) out_tready = ~out_tready;
    end
  end

  task automatic hs_wait(input bit is_end);
    int t;
    t = 0;
    forever begin
      @(negedge clock);
      if (is_end ? end_tready : first_tready) break;
      t++;
      if (t > 300) begin
        checks++;
        errors++;
        $display("FAIL hs_timeout: end=%0d got no tready, required tready within 300 cycles", is_end);
        break;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drive_first(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      first_tvalid = 1'b1;
      first_tdata  = base + 8'(i);
      first_tlast  = (i == n - 1);
      hs_wait(1'b0);
    end
    first_tvalid = 1'b0;
    first_tlast  = 1'b0;
  endtask

  task automatic drive_end(input int n, input logic [7:0] base, input bit do_last);
    for (int i = 0; i < n; i++) begin
      end_tvalid = 1'b1;
      end_tdata  = base + 8'(i);
      end_tlast  = do_last && (i == n - 1);
      hs_wait(1'b1);
    end
    end_tvalid = 1'b0;
    end_tlast  = 1'b0;
  endtask

  task automatic run_pair(input int flen, input int elen, input int lead, input int exp_len,
                          input logic [7:0] fbase, input logic [7:0] ebase);
    for (int i = 0; i < flen; i++) exp_q.push_back({1'b0, fbase + 8'(i)});
    for (int i = 0; i < elen; i++) exp_q.push_back({(i == elen - 1), ebase + 8'(i)});
    len_q.push_back(exp_len);
    len4_q.push_back((flen > 15) ? 15 : flen);
    fork
      begin
        if (lead > 0) begin
          bit bad;
          bad = 1'b0;
          for (int c = 0; c < lead; c++) begin
            @(negedge clock);
            if (end_tready) bad = 1'b1;
          end
          chk("end_held_off", {31'd0, bad}, 32'd0);
          @(posedge clock);
          #1;
        end
        drive_first(flen, fbase);
      end
      drive_end(elen, ebase, 1'b1);
    join
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || len_q.size() != 0 || len4_q.size() != 0) && t < 1000) begin
      @(negedge clock);
      t++;
    end
    chk("drain_empty", exp_q.size() + len_q.size() + len4_q.size(), 0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    vec_t vecs[5];
    vecs[0] = '{flen: 3, elen: 2, lead: 0,  exp_len: 3};
    vecs[1] = '{flen: 2, elen: 3, lead: 10, exp_len: 2};
    vecs[2] = '{flen: 1, elen: 1, lead: 0,  exp_len: 1};
    vecs[3] = '{flen: 4, elen: 1, lead: 0,  exp_len: 4};
    vecs[4] = '{flen: 1, elen: 5, lead: 0,  exp_len: 1};

    rst = 1'b1;
    first_tdata = '0; first_tvalid = 1'b0; first_tlast = 1'b0;
    end_tdata = '0; end_tvalid = 1'b0; end_tlast = 1'b0;
    out_tready = 1'b0; len_tready = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_out_tvalid", out_tvalid, 0);
    chk("rst_len_tvalid", len_tvalid, 0);
    chk("rst_len_ovf", len_ovf, 0);
    chk("rst_first_tready", first_tready, 0);
    chk("rst_end_tready", end_tready, 0);
    @(posedge clock);
    #1;
    rst = 1'b0;
    out_tready = 1'b1;
    len_tready = 1'b1;
    mon_en = 1'b1;

    for (int v = 0; v < 5; v++) begin
      max_run = 0;
      run_pair(vecs[v].flen, vecs[v].elen, vecs[v].lead, vecs[v].exp_len,
               8'hA0 + 8'(v * 16), 8'hB0 + 8'(v * 16));
      drain();
      if (v == 0) chk("back_to_back_run", max_run, 5);
    end

    tog_en = 1'b1;
    for (int p = 0; p < 50; p++) begin
      int fl;
      int el;
      fl = int'($urandom_range(1, 8));
      el = int'($urandom_range(1, 8));
      run_pair(fl, el, 0, fl, 8'($urandom), 8'($urandom));
    end
    drain();
    tog_en = 1'b0;
    out_tready = 1'b1;

    len_tready = 1'b0;
    for (int k = 1; k <= 4; k++) run_pair(k, 1, 0, k, 8'h10 * 8'(k), 8'hF0);
    fork
      run_pair(5, 1, 0, 5, 8'h50, 8'hF5);
      begin
        repeat (20) @(negedge clock);
        chk("len_full_stall_ready", first_tready, 0);
        chk("len_full_stall_last", first_tvalid & first_tlast, 1);
        @(posedge clock);
        #1;
        len_tready = 1'b1;
      end
    join
    drain();

    run_pair(17, 2, 0, 17, 8'h00, 8'hE0);
    drain();
    chk("ovf_set_lsize4", len4_ovf, 1);
    chk("ovf_clear_lsize16", len_ovf, 0);
    run_pair(2, 2, 0, 2, 8'h30, 8'h40);
    drain();
    chk("ovf_sticky", len4_ovf, 1);

    mon_en = 1'b0;
    drive_first(2, 8'hD0);
    drive_end(2, 8'hE0, 1'b0);
    rst = 1'b1;
    @(negedge clock);
    chk("rst_mid_first_tready", first_tready, 0);
    chk("rst_mid_end_tready", end_tready, 0);
    @(posedge clock);
    #1;
    rst = 1'b0;
    @(negedge clock);
    chk("post_rst_out_tvalid", out_tvalid, 0);
    chk("post_rst_len_tvalid", len_tvalid, 0);
    chk("post_rst_state_first", first_tready, 1);
    chk("post_rst_state_end", end_tready, 0);
    chk("post_rst_ovf", len4_ovf, 0);
    @(posedge clock);
    #1;
    mon_en = 1'b1;
    run_pair(3, 2, 0, 3, 8'h60, 8'h70);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
